mod_acc_seq: RTL and testbench

MOD_ACC_SEQ -- requirements
Module: mod_acc_seq

---
 rtl/mod_acc_seq_pkg.sv | 14 +
 rtl/mod_acc_seq_add_core.sv | 23 ++
 rtl/mod_acc_seq.sv | 124 ++++++++++++
 tb/tb_mod_acc_seq.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mod_acc_seq_pkg.sv
// Shared constants and FSM state encoding for the modular accumulator.
// The optional range check is enabled by defining MOD_ACC_RANGE_CHK_EN.
package mod_acc_seq_pkg;

   localparam int DEF_DATA_WIDTH = 32;
   localparam int DEF_LEN_WIDTH  = 16;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/mod_acc_seq_add_core.sv
// Combinational (a + b) mod q for a, b in [0, q).
// Uses one conditional subtraction on a DATA_WIDTH+1 bit sum, so it cannot overflow.
module mod_add_core
   import mod_acc_seq_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
   input  logic [DATA_WIDTH-1:0] i_a,
   input  logic [DATA_WIDTH-1:0] i_b,
   input  logic [DATA_WIDTH-1:0] i_q,
   output logic [DATA_WIDTH-1:0] o_sum
);

   logic [DATA_WIDTH:0] w_sum;
   logic [DATA_WIDTH:0] w_diff;
   logic                w_ge;

   assign w_sum  = {1'b0, i_a} + {1'b0, i_b};
   assign w_diff = w_sum - {1'b0, i_q};
   assign w_ge   = (w_sum >= {1'b0, i_q});
   assign o_sum  = w_ge ? w_diff[DATA_WIDTH-1:0] : w_sum[DATA_WIDTH-1:0];

endmodule

// File: rtl/mod_acc_seq.sv
// Sequential modular accumulator: sums len beats of in_data modulo Q.
// Define MOD_ACC_RANGE_CHK_EN to build the sticky out-of-range err flag.
//
// Handshake: a beat transfers on a rising edge where in_valid && in_ready;
// start is taken only on an edge where ready is high; in_valid need not be
// held and in_data is sampled only on a transfer.
module mod_acc_seq
   import mod_acc_seq_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int LEN_WIDTH  = DEF_LEN_WIDTH
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         start,
   input  logic [LEN_WIDTH-1:0]         len,
   input  logic signed [DATA_WIDTH-1:0] Q,
   input  logic                         in_valid,
   input  logic signed [DATA_WIDTH-1:0] in_data,
   output logic                         in_ready,
   output logic signed [DATA_WIDTH-1:0] out,
   output logic                         ready,
   output logic                         done,
   output logic                         err,
   output logic [1:0]                   dbg_state
);

   state_t                r_state;
   state_t                w_next;
   logic [DATA_WIDTH-1:0] r_acc;
   logic [DATA_WIDTH-1:0] r_q;
   logic [LEN_WIDTH-1:0]  r_len;
   logic [LEN_WIDTH-1:0]  r_cnt;
   logic [DATA_WIDTH-1:0] w_sum;
   logic                  w_start_acc;
   logic                  w_beat;
   logic                  w_last;

   assign w_start_acc = (r_state == ST_IDLE) && start;
   assign w_beat      = (r_state == ST_RUN) && in_valid;
   assign w_last      = (r_cnt == r_len - LEN_WIDTH'(1));

   mod_add_core #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_add (
      .i_a   (r_acc),
      .i_b   (in_data),
      .i_q   (r_q),
      .o_sum (w_sum)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE: if (start) w_next = (len == '0) ? ST_DONE : ST_RUN;
         ST_RUN:  if (w_beat && w_last) w_next = ST_DONE;
         ST_DONE: w_next = ST_IDLE;
         default: w_next = ST_IDLE;
      endcase
   end

   always_comb begin
      ready    = 1'b0;
      in_ready = 1'b0;
      done     = 1'b0;
      case (r_state)
         ST_IDLE: ready    = 1'b1;
         ST_RUN:  in_ready = 1'b1;
         ST_DONE: done     = 1'b1;
         default: ready    = 1'b0;
      endcase
   end

   // len and Q are captured on start so later input changes cannot disturb a run.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_acc <= '0;
         r_cnt <= '0;
         r_len <= '0;
         r_q   <= '0;
      end else if (w_start_acc) begin
         r_acc <= '0;
         r_cnt <= '0;
         r_len <= len;
         r_q   <= Q;
      end else if (w_beat) begin
         r_acc <= w_sum;
         r_cnt <= r_cnt + LEN_WIDTH'(1);
      end
   end

`ifdef MOD_ACC_RANGE_CHK_EN
   logic r_err;
   logic w_range_bad;

   assign w_range_bad = in_data[DATA_WIDTH-1] | (in_data >= r_q);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_err <= 1'b0;
      end else if (w_start_acc) begin
         r_err <= 1'b0;
      end else if (w_beat && w_range_bad) begin
         r_err <= 1'b1;
      end
   end

   assign err = r_err;
`else
   assign err = 1'b0;
`endif

   assign out       = r_acc;
   assign dbg_state = r_state;

endmodule

// File: tb/tb_mod_acc_seq.sv
// Directed bench for mod_acc_seq with a spec-level accumulation model and scoreboard.
module tb_mod_acc_seq;

   localparam logic [31:0] QV = 32'h07FF_F801;
`ifdef MOD_ACC_RANGE_CHK_EN
   localparam logic [63:0] EXP_ERR = 64'd1;
`else
   localparam logic [63:0] EXP_ERR = 64'd0;
`endif

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic               start = 1'b0;
   logic [15:0]        len = '0;
   logic signed [31:0] Q = '0;
   logic               in_valid = 1'b0;
   logic signed [31:0] in_data = '0;
   logic               in_ready;
   logic signed [31:0] out;
   logic               ready;
   logic               done;
   logic               err;
   logic [1:0]         dbg_state;

   int n_pass = 0;
   int n_total = 0;
   int n_done_seen = 0;

   // model: phase 0 = idle, 1 = accumulating, 2 = completion cycle
   bit     m_valid = 1'b0;
   int     m_phase = 0;
   longint m_acc = 0;
   longint m_q = 1;
   int     m_len = 0;
   int     m_cnt = 0;
   bit     m_err = 1'b0;
   logic [31:0] exp_q[$];

   always #5 clk = ~clk;

   mod_acc_seq dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .len       (len),
      .Q         (Q),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .out       (out),
      .ready     (ready),
      .done      (done),
      .err       (err),
      .dbg_state (dbg_state)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // Behavioural model: the result is the running sum modulo Q of the accepted beats.
   always @(posedge clk) begin
      longint d;
      if (rst) begin
         m_valid = 1'b1;
         m_phase = 0;
         m_acc   = 0;
         m_cnt   = 0;
         m_err   = 1'b0;
      end else if (m_valid) begin
         case (m_phase)
            0: if (start) begin
               m_len = int'(len);
               m_q   = longint'({32'b0, Q});
               m_acc = 0;
               m_cnt = 0;
               m_err = 1'b0;
               m_phase = (m_len == 0) ? 2 : 1;
               if (m_phase == 2) exp_q.push_back(32'd0);
            end
            1: if (in_valid) begin
               d = longint'(in_data);
`ifdef MOD_ACC_RANGE_CHK_EN
               if (d < 0 || d >= m_q) m_err = 1'b1;
`endif
               m_acc = (m_acc + d) % m_q;
               m_cnt++;
               if (m_cnt == m_len) begin
                  m_phase = 2;
                  exp_q.push_back(m_acc[31:0]);
               end
            end
            default: m_phase = 0;
         endcase
      end
   end

   always @(negedge clk) begin
      logic [31:0] e;
      if (m_valid) begin
         chk("out", {32'b0, out}, m_acc);
         chk("ready", {63'b0, ready}, {63'b0, m_phase == 0});
         chk("in_ready", {63'b0, in_ready}, {63'b0, m_phase == 1});
         chk("done", {63'b0, done}, {63'b0, m_phase == 2});
         chk("err", {63'b0, err}, {63'b0, m_err});
         if (done) begin
            n_done_seen++;
            if (exp_q.size() == 0) chk("done_unexpected", 64'd1, 64'd0);
            else begin
               e = exp_q.pop_front();
               chk("done_result", {32'b0, out}, {32'b0, e});
            end
         end
      end
   end

   task automatic cyc(input int n);
      repeat (n) begin
         @(negedge clk);
         #1;
      end
   endtask

   task automatic do_start(input logic [15:0] l, input logic [31:0] q);
      start = 1'b1;
      len   = l;
      Q     = q;
      cyc(1);
      start = 1'b0;
      len   = 16'($urandom_range(0, 65535));
      Q     = 32'($urandom_range(1, 1000));
   endtask

   task automatic beat(input logic [31:0] d);
      int k = 0;
      while (!in_ready && k < 100) begin
         cyc(1);
         k++;
      end
      if (k == 100) chk("in_ready_timeout", 64'd1, 64'd0);
      in_valid = 1'b1;
      in_data  = d;
      cyc(1);
      in_valid = 1'b0;
      in_data  = 32'($urandom);
   endtask

   initial begin
      int dn;
      cyc(2);
      rst = 1'b0;
      chk("rst_out", {32'b0, out}, 64'd0);
      chk("rst_ready", {63'b0, ready}, 64'd1);
      chk("rst_in_ready", {63'b0, in_ready}, 64'd0);
      chk("rst_done", {63'b0, done}, 64'd0);
      chk("rst_err", {63'b0, err}, 64'd0);
      cyc(1);

      // wrap-around case: 0x07FFF800 + 0x200 folds to 0x1FF
      do_start(16'd2, QV);
      beat(32'h07FF_F800);
      beat(32'h0000_0200);
      chk("wrap_done", {63'b0, done}, 64'd1);
      chk("wrap_out", {32'b0, out}, 64'h1FF);
      chk("wrap_model", m_acc, 64'h1FF);
      cyc(3);
      chk("hold_out", {32'b0, out}, 64'h1FF);
      chk("hold_ready", {63'b0, ready}, 64'd1);

      // len = 0: done straight after start, no beats taken
      in_valid = 1'b1;
      in_data  = 32'd77;
      do_start(16'd0, QV);
      chk("len0_done", {63'b0, done}, 64'd1);
      chk("len0_out", {32'b0, out}, 64'd0);
      cyc(1);
      in_valid = 1'b0;
      chk("len0_ready", {63'b0, ready}, 64'd1);
      chk("len0_out_idle", {32'b0, out}, 64'd0);

      // gaps between beats hold state
      do_start(16'd3, QV);
      beat(32'd5);
      cyc(2);
      beat(32'd7);
      cyc(2);
      chk("gap_no_early_done", {63'b0, done}, 64'd0);
      beat(32'd9);
      chk("gap_done", {63'b0, done}, 64'd1);
      chk("gap_out", {32'b0, out}, 64'd21);
      chk("gap_model", m_acc, 64'd21);
      cyc(1);

      // start pulse and len/Q changes during RUN are ignored
      do_start(16'd2, QV);
      beat(32'h07FF_F800);
      start = 1'b1;
      len   = 16'd5;
      Q     = 32'd100;
      cyc(1);
      start = 1'b0;
      beat(32'h0000_0200);
      chk("ign_done", {63'b0, done}, 64'd1);
      chk("ign_out", {32'b0, out}, 64'h1FF);
      cyc(1);

      // reset mid-run aborts without done
      dn = n_done_seen;
      do_start(16'd4, QV);
      beat(32'd11);
      chk("abort_pre_out", {32'b0, out}, 64'd11);
      rst = 1'b1;
      in_valid = 1'b1;
      start = 1'b1;
      cyc(1);
      rst = 1'b0;
      in_valid = 1'b0;
      start = 1'b0;
      chk("abort_out", {32'b0, out}, 64'd0);
      chk("abort_ready", {63'b0, ready}, 64'd1);
      cyc(3);
      chk("abort_no_done", 64'(n_done_seen), 64'(dn));

      // out-of-range beat (== Q)
      do_start(16'd2, QV);
      beat(QV);
      chk("range_err", {63'b0, err}, EXP_ERR);
      beat(32'd3);
      chk("range_done", {63'b0, done}, 64'd1);
      chk("range_out", {32'b0, out}, 64'd3);
      cyc(2);
      chk("range_err_held", {63'b0, err}, EXP_ERR);
      do_start(16'd1, QV);
      chk("range_err_cleared", {63'b0, err}, 64'd0);
      beat(32'd1);
      cyc(1);

      // small modulus, random in-range data, random gaps
      do_start(16'd6, 32'd13);
      for (int i = 0; i < 6; i++) begin
         beat(32'($urandom_range(0, 12)));
         cyc($urandom_range(0, 2));
      end
      cyc(3);

      chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
